controle_pilha: RTL

CONTROLE_PILHA -- requirements
Module: controle_pilha

---
 rtl/controle_pilha_pkg.sv | 23 ++
 rtl/contador_pilha.sv | 57 +++++
 rtl/controle_pilha.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/controle_pilha_pkg.sv
// rtl/controle_pilha_pkg.sv - shared defaults and FSM encoding for the stack controller
//
// Purpose: holds the default word width, stack depth and address width used by
//          controle_pilha and contador_pilha, plus the controller state encoding.
// Contents:
//   LARGURA_PADRAO  - default data word width (16)
//   TAMANHO_PADRAO  - default stack depth in words (64)
//   ENDERECO_PADRAO - default address width, log2 of depth (6)
//   estado_t        - controller states OCIOSO/ESCREVE/LE/CAPTURA (2-bit)
package controle_pilha_pkg;

  localparam int LARGURA_PADRAO  = 16;
  localparam int TAMANHO_PADRAO  = 64;
  localparam int ENDERECO_PADRAO = 6;

  typedef enum logic [1:0] {
    OCIOSO  = 2'd0,
    ESCREVE = 2'd1,
    LE      = 2'd2,
    CAPTURA = 2'd3
  } estado_t;

endpackage : controle_pilha_pkg

// File: rtl/contador_pilha.sv
// rtl/contador_pilha.sv - saturating stack occupancy counter with full/empty decode
//
// Purpose: tracks how many words are on the stack. Increments on inc, decrements
//          on dec, never goes above Tamanho_da_pilha nor below zero.
// Ports:
//   clk      in   clock, rising edge
//   rst_n    in   asynchronous active-low reset, clears the count
//   inc      in   add one word (closing edge of a write)
//   dec      in   remove one word (closing edge of a read)
//   contagem out  current occupancy, Tamanho_endereco+1 bits
//   cheia    out  occupancy equals Tamanho_da_pilha (combinational)
//   vazia    out  occupancy equals zero (combinational)
module contador_pilha
  import controle_pilha_pkg::*;
#(
  parameter int Tamanho_da_pilha = TAMANHO_PADRAO,
  parameter int Tamanho_endereco = ENDERECO_PADRAO
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    inc,
  input  logic                    dec,
  output logic [Tamanho_endereco:0] contagem,
  output logic                    cheia,
  output logic                    vazia
);

  localparam logic [Tamanho_endereco:0] CHEIO = Tamanho_da_pilha[Tamanho_endereco:0];
  localparam logic [Tamanho_endereco:0] ZERO  = '0;

  logic [Tamanho_endereco:0] contagem_q;
  logic [Tamanho_endereco:0] contagem_d;

  // The FSM never asks for both at once, but the guards keep the count inside
  // [0, depth] even if it did.
  always_comb begin
    contagem_d = contagem_q;
    if (inc && !dec && (contagem_q != CHEIO)) begin
      contagem_d = contagem_q + 1'b1;
    end else if (dec && !inc && (contagem_q != ZERO)) begin
      contagem_d = contagem_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      contagem_q <= '0;
    end else begin
      contagem_q <= contagem_d;
    end
  end

  assign contagem = contagem_q;
  assign cheia    = (contagem_q == CHEIO);
  assign vazia    = (contagem_q == ZERO);

endmodule : contador_pilha

// File: rtl/controle_pilha.sv
// rtl/controle_pilha.sv - LIFO stack controller driving an external single-port memory
//
// Purpose: accepts push/pop requests while idle, sequences the external memory
//          (write in one cycle, read in two), and reports the popped word.
// Ports:
//   clk, rst_n  clock (rising edge) and asynchronous active-low reset
//   push, pop   requests, sampled only in OCIOSO; push wins if both are set
//   dado_in     word to push
//   dado_out    popped word, held until the next pop completes
//   valido_out  one-cycle pulse when dado_out carries a new pop result
//   ocupado     an operation is in progress
//   cheia/vazia occupancy at depth / at zero
//   erro        one-cycle pulse for a rejected or conflicting request
//   contagem    current occupancy
//   Endereco    memory address, zero-extended
//   io          memory direction, 1 = write, 0 = read
//   mem_wdata   write data towards memory
//   mem_rdata   registered read data from memory
module controle_pilha
  import controle_pilha_pkg::*;
#(
  parameter int Largura_da_pilha = LARGURA_PADRAO,
  parameter int Tamanho_da_pilha = TAMANHO_PADRAO,
  parameter int Tamanho_endereco = ENDERECO_PADRAO
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        push,
  input  logic                        pop,
  input  logic [Largura_da_pilha-1:0] dado_in,
  output logic [Largura_da_pilha-1:0] dado_out,
  output logic                        valido_out,
  output logic                        ocupado,
  output logic                        cheia,
  output logic                        vazia,
  output logic                        erro,
  output logic [Tamanho_endereco:0]   contagem,
  output logic [Largura_da_pilha-1:0] Endereco,
  output logic                        io,
  output logic [Largura_da_pilha-1:0] mem_wdata,
  input  logic [Largura_da_pilha-1:0] mem_rdata
);

  estado_t                       estado_q, estado_d;
  logic [Tamanho_endereco-1:0]   end_q, end_d;
  logic                          io_q, io_d;
  logic [Largura_da_pilha-1:0]   wdata_q, wdata_d;
  logic [Largura_da_pilha-1:0]   dado_q, dado_d;
  logic                          valido_q, valido_d;
  logic                          erro_q, erro_d;

  logic                          inc;
  logic                          dec;
  logic [Tamanho_endereco:0]     contagem_menos_um;
  logic [Largura_da_pilha-1:0]   barramento;

  contador_pilha #(
    .Tamanho_da_pilha (Tamanho_da_pilha),
    .Tamanho_endereco (Tamanho_endereco)
  ) u_contador (
    .clk      (clk),
    .rst_n    (rst_n),
    .inc      (inc),
    .dec      (dec),
    .contagem (contagem),
    .cheia    (cheia),
    .vazia    (vazia)
  );

  // Shared memory data bus: carries our write word while io=1, otherwise the
  // memory's read data. Pop results are taken from this bus.
  assign barramento = io_q ? wdata_q : mem_rdata;

  assign contagem_menos_um = contagem - 1'b1;

  always_comb begin
    estado_d = estado_q;
    end_d    = end_q;
    io_d     = io_q;
    wdata_d  = wdata_q;
    dado_d   = dado_q;
    valido_d = 1'b0;
    erro_d   = 1'b0;
    inc      = 1'b0;
    dec      = 1'b0;

    case (estado_q)
      OCIOSO: begin
        io_d = 1'b0;
        if (push) begin
          // Simultaneous pop is dropped and flagged; the push still runs.
          if (pop) begin
            erro_d = 1'b1;
          end
          if (!cheia) begin
            wdata_d  = dado_in;
            end_d    = contagem[Tamanho_endereco-1:0];
            io_d     = 1'b1;
            estado_d = ESCREVE;
          end else begin
            erro_d = 1'b1;
          end
        end else if (pop) begin
          if (!vazia) begin
            end_d    = contagem_menos_um[Tamanho_endereco-1:0];
            io_d     = 1'b0;
            estado_d = LE;
          end else begin
            erro_d = 1'b1;
          end
        end
      end

      ESCREVE: begin
        inc      = 1'b1;
        io_d     = 1'b0;
        estado_d = OCIOSO;
      end

      // Memory registers the read word on the edge closing this state.
      LE: begin
        estado_d = CAPTURA;
      end

      CAPTURA: begin
        dado_d   = barramento;
        valido_d = 1'b1;
        dec      = 1'b1;
        estado_d = OCIOSO;
      end

      default: begin
        estado_d = OCIOSO;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado_q <= OCIOSO;
      end_q    <= '0;
      io_q     <= 1'b0;
      wdata_q  <= '0;
      dado_q   <= '0;
      valido_q <= 1'b0;
      erro_q   <= 1'b0;
    end else begin
      estado_q <= estado_d;
      end_q    <= end_d;
      io_q     <= io_d;
      wdata_q  <= wdata_d;
      dado_q   <= dado_d;
      valido_q <= valido_d;
      erro_q   <= erro_d;
    end
  end

  assign ocupado    = (estado_q != OCIOSO);
  assign io         = io_q;
  assign Endereco   = Largura_da_pilha'(end_q);
  assign mem_wdata  = wdata_q;
  assign dado_out   = dado_q;
  assign valido_out = valido_q;
  assign erro       = erro_q;

endmodule : controle_pilha
